accel_tilt_prefilter: RTL
=========================

// Module: accel_tilt_prefilter
// PURPOSE
//   Per-axis boxcar (moving-average) filter on raw signed accelerometer samples.
//   Sits directly upstream of the arctan stage and produces its x/y operand pair.
//   Smooths sensor noise so the tilt angle does not jitter.
//   Accepts one sample pair per cycle and emits a filtered pair with a 1-cycle valid strobe.
// PARAMETERS
//   DATA_W      16  sample/output width, signed two's complement
//   LOG2_DEPTH  3   averaging window = 2**LOG2_DEPTH samples (8); legal range 1..6
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst        in   1       synchronous, active-high reset
//   clear      in   1       synchronous window flush, same effect as rst
//   in_valid   in   1       ax/ay carry a new sample this cycle
//   ax         in   DATA_W  raw X-axis sample, signed
//   ay         in   DATA_W  raw Y-axis sample, signed
//   x          out  DATA_W  filtered X, signed; feeds arctan x
//   y          out  DATA_W  filtered Y, signed; feeds arctan y
//   out_valid  out  1       one-cycle strobe: x/y updated this cycle
//   off_x      in   DATA_W  X offset, signed (only with ACCEL_OFFSET_EN)
//   off_y      in   DATA_W  Y offset, signed (only with ACCEL_OFFSET_EN)
// BEHAVIOUR
//   - Reset/clear: x=0, y=0, out_valid=0, sums=0, wr_ptr=0, fill count=0, state=FILL.
//     Sample RAM is not cleared.
//   - rst or clear on the same edge as in_valid: flush wins, sample discarded.
//   - No backpressure; one sample per cycle sustained. Idle cycles: x/y hold, out_valid=0.
//   - Storage: per axis, a 2**LOG2_DEPTH-entry circular buffer and a running sum
//     of width DATA_W+LOG2_DEPTH (cannot overflow).
//   - Accept edge: old = buf[wr_ptr] (forced to 0 in FILL).
//     sum <= sum + s - old; buf[wr_ptr] <= s; wr_ptr wraps 2**LOG2_DEPTH-1 -> 0.
//   - Output: x/y <= (sum + s - old) >>> LOG2_DEPTH on the accept edge,
//     i.e. arithmetic shift, truncation toward -inf.
//     out_valid is high in the cycle after the accept edge (latency 1) when the window is full.
//   - FSM FILL: count accepted samples; out_valid suppressed. The 2**LOG2_DEPTH-th
//     accepted sample moves FILL->RUN and produces the first out_valid.
//   - FSM RUN: every accepted sample produces out_valid. Only rst/clear returns to FILL.
//   - Window boundary: wr_ptr wrap and FILL->RUN may coincide; the wrapping sample's own
//     old value is still 0 (FILL rule).
// CONFIGURATION
//   ACCEL_OFFSET_EN defined:
//     - off_x/off_y ports exist.
//     - s = sat(ax-off_x), sat(ay-off_y), computed DATA_W+1 wide and saturated to
//       [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//     - Offsets are sampled on the same edge as ax/ay; no extra latency.
//   ACCEL_OFFSET_EN undefined: ports absent, s = ax/ay unchanged.
// TESTING (DATA_W=16, LOG2_DEPTH=3)
//   1. rst, then 8 back-to-back samples ax=16'h2800, ay=16'h2000
//      -> out_valid low for first 7, single pulse after 8th; x=16'h2800, y=16'h2000.
//   2. Continue with ax=16'h2000, ay=16'h2800: after 4th new sample x=y=16'h2400;
//      after 8th x=16'h2000, y=16'h2800; out_valid every cycle.
//   3. Fill with 7x ax=16'hFFFF, 1x ax=16'h0000 -> x=16'hFFFF (floor of -7/8).
//   4. Fill ax=16'h7FFF, ay=16'h8000 x8 -> x=16'h7FFF, y=16'h8000, no wrap.
//   5. 5 samples, then clear with in_valid=1 ax=16'h1000, then 8 samples ax=16'h0800
//      -> no out_valid until 8th post-clear sample; x=16'h0800.
//      Repeat with rst asserted at the same point -> identical result.
//   6. ACCEL_OFFSET_EN: off_x=16'h0800, ax=16'h2800 x8 -> x=16'h2000;
//      off_x=16'h8000, ax=16'h7FFF x8 -> x=16'h7FFF (saturated).

Source files
------------

// File: rtl/accel_tilt_prefilter.sv
// Per-axis boxcar (moving-average) prefilter for the x/y operands of the arctan tilt stage.
// Optional input offset correction with saturation is enabled by defining ACCEL_OFFSET_EN.
module accel_tilt_prefilter #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ax,
  input  logic [DATA_W-1:0] ay,
`ifdef ACCEL_OFFSET_EN
  input  logic [DATA_W-1:0] off_x,
  input  logic [DATA_W-1:0] off_y,
`endif
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              out_valid
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

  state_e state_q, state_d;

  logic                     flush;
  logic                     accept;
  logic [LOG2_DEPTH-1:0]    wr_ptr_q;
  logic signed [SUM_W-1:0]  sum_x_q, sum_y_q;
  logic signed [SUM_W-1:0]  sum_x_d, sum_y_d;
  logic signed [SUM_W-1:0]  avg_x, avg_y;
  logic signed [DATA_W-1:0] s_x, s_y;
  logic signed [DATA_W-1:0] old_x, old_y;
  logic signed [DATA_W-1:0] mem_x_q [DEPTH];
  logic signed [DATA_W-1:0] mem_y_q [DEPTH];
  logic [DATA_W-1:0]        x_q, y_q;
  logic                     out_valid_q, out_valid_d;

  assign flush  = rst | clear;
  assign accept = in_valid & ~flush;

`ifdef ACCEL_OFFSET_EN
  function automatic logic signed [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (d[DATA_W] != d[DATA_W-1])
      return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return d[DATA_W-1:0];
  endfunction

  assign s_x = sat_sub(ax, off_x);
  assign s_y = sat_sub(ay, off_y);
`else
  assign s_x = ax;
  assign s_y = ay;
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next-state logic: during FILL the write pointer doubles as the fill count.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (in_valid && state_q == FILL && wr_ptr_q == LOG2_DEPTH'(DEPTH - 1))
      state_d = RUN;
  end

  // Output logic: samples leaving the window count as 0 until it has been filled once.
  always_comb begin
    old_x       = '0;
    old_y       = '0;
    out_valid_d = 1'b0;
    if (state_q == RUN) begin
      old_x = mem_x_q[wr_ptr_q];
      old_y = mem_y_q[wr_ptr_q];
    end
    if (in_valid && state_d == RUN)
      out_valid_d = 1'b1;
  end

  always_comb begin
    sum_x_d = sum_x_q + SUM_W'(s_x) - SUM_W'(old_x);
    sum_y_d = sum_y_q + SUM_W'(s_y) - SUM_W'(old_y);
    avg_x   = sum_x_d >>> LOG2_DEPTH;
    avg_y   = sum_y_d >>> LOG2_DEPTH;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q    <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        sum_x_q  <= sum_x_d;
        sum_y_q  <= sum_y_d;
        x_q      <= avg_x[DATA_W-1:0];
        y_q      <= avg_y[DATA_W-1:0];
      end
    end
  end

  // NOTE: sample storage has no reset; FILL masks stale contents until overwritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_x_q[wr_ptr_q] <= s_x;
      mem_y_q[wr_ptr_q] <= s_y;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule
